// File: rtl/skid_reg_if.sv
// Valid/ready handshake bundle for skid_reg: upstream (in*) and downstream (out*) sides.
// slave = the skid register itself; master = the surrounding producer/consumer.
interface skid_reg_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );

endinterface : skid_reg_if

// File: rtl/skid_reg.sv
// Two-entry skid buffer: registered in_ready, one word per cycle, lossless under stall.
// Optional SKID_REG_STALL_CNT_EN adds a saturating 16-bit stall_count output.
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  skid_reg_if.slave      bus
`ifdef SKID_REG_STALL_CNT_EN
  ,
  output logic [15:0]    stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  assign bus.out       = r_main;
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = r_in_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_nxt  = bus.in;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = bus.in;
        end else if (w_in_fire) begin
          w_skid_nxt  = bus.in;
          w_state_nxt = ST_SKID;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the downstream side can move.
        if (w_out_fire) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, so out reads 0 (not stale data) after reset.
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      // Ready comes from the next state so it never depends combinationally on out_ready.
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

`ifdef SKID_REG_STALL_CNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule : skid_reg

// File: tb/tb_skid_reg.sv
// Directed and scoreboarded checks for skid_reg: reset, streaming, skid, mid-op reset,
// random handshake traffic and (with SKID_REG_STALL_CNT_EN) the stall counter.
module tb_skid_reg;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  skid_reg_if #(.WIDTH(8)) bus ();

`ifdef SKID_REG_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  skid_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SKID_REG_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it, where outputs are sampled and inputs changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic       mv;
    logic       mr;

    // Reset held with a valid word presented: nothing may load.
    reset         = 1'b0;
    bus.in        = 8'hAB;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out", bus.out, 8'h00);
    end
    reset = 1'b1;
    tick();
    check("rel_out", bus.out, 8'hAB);
    check("rel_out_valid", bus.out_valid, 1'b1);
    check("rel_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;

    // Streaming at full rate.
    reset_dut();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in       = 8'(i);
      bus.in_valid = 1'b1;
      tick();
      check("stream_out", bus.out, 32'(i));
      check("stream_out_valid", bus.out_valid, 1'b1);
      check("stream_in_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drain_valid", bus.out_valid, 1'b0);
    check("stream_drain_hold", bus.out, 8'h10);

    // Stall with two words: second goes to the skid slot.
    bus.out_ready = 1'b0;
    bus.in        = 8'hAB;
    bus.in_valid  = 1'b1;
    tick();
    check("skid_first_out", bus.out, 8'hAB);
    check("skid_first_ready", bus.in_ready, 1'b1);
    bus.in = 8'hCD;
    tick();
    check("skid_hold_out", bus.out, 8'hAB);
    check("skid_in_ready", bus.in_ready, 1'b0);
    check("skid_out_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0;
    bus.in       = 8'h55;
    tick();
    check("skid_stall_out", bus.out, 8'hAB);
    check("skid_stall_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("skid_second_out", bus.out, 8'hCD);
    check("skid_second_valid", bus.out_valid, 1'b1);
    check("skid_ready_back", bus.in_ready, 1'b1);
    tick();
    check("skid_empty_valid", bus.out_valid, 1'b0);
    check("skid_empty_hold", bus.out, 8'hCD);

    // Reset while both slots are occupied discards both words.
    bus.out_ready = 1'b0;
    bus.in        = 8'hAB;
    bus.in_valid  = 1'b1;
    tick();
    bus.in = 8'hCD;
    tick();
    bus.in_valid = 1'b0;
    check("midrst_pre_ready", bus.in_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_out", bus.out, 8'h00);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_idle_valid", bus.out_valid, 1'b0);
      check("midrst_idle_out", bus.out, 8'h00);
    end

    // Random traffic against a queue model of the two-entry buffer.
    reset_dut();
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      check("rand_out_valid", bus.out_valid, (q.size() != 0));
      check("rand_in_ready", bus.in_ready, (q.size() < 2));
      if (q.size() != 0) check("rand_out", bus.out, q[0]);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in        = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      mv = (q.size() != 0);
      mr = (q.size() < 2);
      if (mv && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && mr) q.push_back(bus.in);
      tick();
    end
    bus.in_valid = 1'b0;

`ifdef SKID_REG_STALL_CNT_EN
    reset_dut();
    check("stall_rst", stall_count, 16'd0);
    bus.in       = 8'h77;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("stall_load", stall_count, 16'd0);
    repeat (10) tick();
    check("stall_ten", stall_count, 16'd10);
    repeat (70000) tick();
    check("stall_sat", stall_count, 16'hFFFF);
    check("stall_sat_out", bus.out, 8'h77);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stall_clear", stall_count, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_skid_reg
